// File: rtl/alu_comm_pkg.sv
// Shared ALU library package: divider FSM state type and counter sizing helper.
package alu_comm_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    function automatic int unsigned calc_cnt_width(int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore.
module alu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   new_rem,
    output logic             quo_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {part_rem, next_bit};
        diff    = shifted - {2'b00, divisor};
        // Non-negative trial result keeps the subtraction and yields a 1 bit.
        quo_bit = ~diff[WIDTH+1];
        new_rem = quo_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/alu_seq_div.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed operation is compiled in only when ALU_DIV_SIGNED_EN is defined.
module alu_seq_div
    import alu_comm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = calc_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CntW-1:0]  cnt_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] quo_q, rmd_q;
    logic             dbz_q;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg_quo_d, neg_rem_d;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] fin_quo, fin_rem;

    alu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .part_rem (rem_q),
        .next_bit (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .new_rem  (step_rem),
        .quo_bit  (step_bit)
    );

`ifdef ALU_DIV_SIGNED_EN
    always_comb begin
        mag_a     = dividend;
        mag_b     = divisor;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        if (is_signed) begin
            if (dividend[WIDTH-1]) mag_a = -dividend;
            if (divisor[WIDTH-1])  mag_b = -divisor;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign mag_a            = dividend;
    assign mag_b            = divisor;
    assign neg_quo_d        = 1'b0;
    assign neg_rem_d        = 1'b0;
`endif

    // Final quotient/remainder as produced by the last iteration, with sign fix-up.
    always_comb begin
        fin_quo = {dvd_q[WIDTH-2:0], step_bit};
        fin_rem = step_rem[WIDTH-1:0];
`ifdef ALU_DIV_SIGNED_EN
        if (neg_quo_q) fin_quo = -fin_quo;
        if (neg_rem_q) fin_rem = -fin_rem;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
            CALC: if (cnt_q == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rem_q     <= '0;
                        dvd_q     <= mag_a;
                        dsr_q     <= mag_b;
                        cnt_q     <= CntW'(WIDTH - 1);
                        neg_quo_q <= neg_quo_d;
                        neg_rem_q <= neg_rem_d;
                        if (divisor == '0) begin
                            quo_q <= '1;
                            rmd_q <= dividend;
                            dbz_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_bit};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_q <= fin_quo;
                        rmd_q <= fin_rem;
                        dbz_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_div.sv
// Directed self-checking bench for alu_seq_div at WIDTH=8.
module tb_alu_seq_div;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         is_signed = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq_div #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int waited);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counted as the index of the first cycle after the accept edge with out_valid.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input int elat);
        int waited, lat;
        issue(a, b, s, waited);
        wait_done(lat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, ez);
        consume();
        chk({tag, " idle after consume"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int waited, lat;
        logic [W-1:0] hq, hr;

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("u 100/7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 9);
        run("u 55/0", 8'd55, 8'd0, 1'b0, 8'hFF, 8'd55, 1'b1, 1);
        run("u 249/2", 8'hF9, 8'd2, 1'b0, 8'd124, 8'd1, 1'b0, 9);
        run("u 255/255", 8'hFF, 8'hFF, 1'b0, 8'd1, 8'd0, 1'b0, 9);
        run("u 5/9", 8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0, 9);
`ifdef ALU_DIV_SIGNED_EN
        run("s -7/2", 8'hF9, 8'd2, 1'b1, 8'hFD, 8'hFF, 1'b0, 9);
        run("s MIN/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9);
        run("s 7/-2", 8'd7, 8'hFE, 1'b1, 8'hFD, 8'd1, 1'b0, 9);
        run("s -9/0", 8'hF7, 8'd0, 1'b1, 8'hFF, 8'hF7, 1'b1, 1);
`else
        run("s -7/2 ignored", 8'hF9, 8'd2, 1'b1, 8'd124, 8'd1, 1'b0, 9);
        run("s MIN/-1 ignored", 8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 9);
        run("s 7/-2 ignored", 8'd7, 8'hFE, 1'b1, 8'd0, 8'd7, 1'b0, 9);
        run("s -9/0 ignored", 8'hF7, 8'd0, 1'b1, 8'hFF, 8'hF7, 1'b1, 1);
`endif

        // Backpressure: result must hold while out_ready stays low.
        issue(8'd200, 8'd9, 1'b0, waited);
        wait_done(lat);
        chk("bp latency", lat, 9);
        hq = quotient;
        hr = remainder;
        chk("bp quotient", quotient, 8'd22);
        chk("bp remainder", remainder, 8'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid/ready", {out_valid, in_ready}, 2'b10);
            chk("bp hold data", {quotient, remainder, div_by_zero}, {hq, hr, 1'b0});
        end
        consume();
        chk("bp idle after consume", {out_valid, in_ready}, 2'b01);
        issue(8'd17, 8'd5, 1'b0, waited);
        chk("b2b accepted at once", waited, 0);
        wait_done(lat);
        chk("b2b latency", lat, 9);
        chk("b2b quotient", quotient, 8'd3);
        chk("b2b remainder", remainder, 8'd2);
        consume();

        // Reset in the 4th CALC cycle abandons the operation.
        issue(8'd100, 8'd7, 1'b0, waited);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst mid-calc in_ready", in_ready, 1);
        chk("rst mid-calc out_valid", out_valid, 0);
        chk("rst mid-calc data", {quotient, remainder, div_by_zero}, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst no stale result", out_valid, 0);
        run("after rst 9/3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_div.md
# alu_seq_div

Iterative radix-2 restoring integer divider, the inverse companion to the team's Booth-encoded multiplier in the ALU library. It accepts a dividend/divisor pair over a valid/ready handshake and resolves one quotient bit per cycle. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits beside the multiplier behind the ALU issue stage and shares its common package.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width in bits; must be ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: divider can accept a request.
- `dividend`  in  WIDTH: numerator.
- `divisor`  in  WIDTH: denominator.
- `is_signed`  in  1: two's-complement operands when 1; ignored without `ALU_DIV_SIGNED_EN`.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `quotient`  out  WIDTH: quotient.
- `remainder`  out  WIDTH: remainder.
- `div_by_zero`  out  1: divisor was zero.

## Operation
- FSM with states IDLE, CALC and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch the operand magnitudes, the sign of the quotient, the sign of the remainder, and a zero-divisor flag.
  - Load the iteration counter with WIDTH−1.
  - Go to CALC, or to DONE if the divisor is zero.
- CALC, once per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - The counter decrements each cycle. When it reaches 0, apply the sign fix-up and go to DONE.
- Sign fix-up (signed mode only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE:
  - `out_valid`=1; outputs are held stable.
  - On `out_ready`, go to IDLE.
- Divide by zero: `quotient`=all ones, `remainder`=dividend (unmodified), `div_by_zero`=1.
- Signed overflow (MIN / −1): `quotient`=MIN, `remainder`=0, `div_by_zero`=0. This falls out of magnitude arithmetic and needs no special case.
- Unsigned: plain magnitude result; `div_by_zero` is 0 unless the divisor is 0.
- `in_ready` is asserted only in IDLE. No new request is accepted in the cycle a result is consumed.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State returns to IDLE and `out_valid`=0.
  - `quotient`, `remainder` and `div_by_zero` clear to 0.
  - `in_ready`=1 from the first cycle after reset is released.
- Reset mid-CALC or mid-DONE abandons the operation; no result is produced.
- Latency, from the accept edge to the first cycle with `out_valid`=1:
  - Nonzero divisor: WIDTH+1 cycles (WIDTH in CALC, plus entry to DONE).
  - Zero divisor: 1 cycle.
- Minimum issue interval is WIDTH+2 cycles with `out_ready` tied high.
- Backpressure: `out_valid` stays high and outputs stay bit-stable until `out_ready`. No timeout.
- All outputs are registered. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Configuration
- Macro `ALU_DIV_SIGNED_EN`.
- Defined:
  - `is_signed` selects two's-complement behaviour.
  - Includes the absolute-value input logic and the output negation logic.
- Undefined:
  - `is_signed` is ignored and all operations are unsigned.
  - Sign logic is not compiled in.
  - Ports are unchanged.

## Structure
- Shared package `alu_comm_pkg` gets:
  - typedef `div_state_e` {IDLE, CALC, DONE};
  - function `calc_cnt_width(WIDTH)` returning $clog2(WIDTH), used for the iteration counter width.
- Sub-module `alu_div_step`: purely combinational single restoring iteration.
  - Inputs: partial remainder (WIDTH+1), next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
- The top module holds the FSM, counter, registers and sign logic.

## Test plan
All scenarios use WIDTH=8.
- Unsigned 100 / 7 → `quotient`=14, `remainder`=2, `div_by_zero`=0; `out_valid` exactly 9 cycles after accept.
- 55 / 0 → `quotient`=0xFF, `remainder`=55, `div_by_zero`=1; `out_valid` 1 cycle after accept.
- Signed (macro on, `is_signed`=1) −7 / 2 → `quotient`=0xFD (−3), `remainder`=0xFF (−1). Same operands with the macro off → 249 / 2, `quotient`=124, `remainder`=1.
- Signed 0x80 / 0xFF → `quotient`=0x80, `remainder`=0, `div_by_zero`=0.
- Backpressure: `out_ready` held low for 5 cycles in DONE → outputs stable and `in_ready`=0 throughout. `out_ready`=1 → IDLE next cycle; a back-to-back request is then accepted.
- `rst_n` pulsed low at the 4th CALC cycle → next cycle IDLE, all outputs 0, `in_ready`=1; a fresh 9 / 3 request yields `quotient`=3, `remainder`=0.
